// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//   Iterative AES MixColumns / InvMixColumns. A 128-bit state is captured
//   in IDLE. CALC then produces one output byte per cycle, 16 cycles in all.
//   The result is held in DONE until the consumer accepts it.
//
//   Parameter INVERSE : 0 = forward MixColumns (row 0 = 02 03 01 01),
//                       1 = InvMixColumns     (row 0 = 0e 0b 0d 09).
//
//   Ports
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-high reset
//     in_state   in   128-bit state; byte 0 = [127:120], byte 4c+r = row r, col c
//     in_valid   in   in_state valid this cycle
//     in_ready   out  high only in IDLE
//     out_state  out  mixed state, same byte ordering as in_state
//     out_valid  out  high only in DONE
//     out_ready  in   consumer accepts out_state (only honoured in DONE)
//     busy       out  high only in CALC
// -----------------------------------------------------------------------------
module mix_columns_iter #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Row 0 of the mixing matrix. Each constant fits in a nibble, so the
  // multiplier only ever needs the xtime terms x1, x2, x4 and x8.
  localparam logic [31:0] ROW0 = INVERSE ? 32'h0e0b0d09 : 32'h02030101;

  logic [1:0]   state_q, state_d;
  logic [127:0] in_q, in_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   out_q [16];
  logic [7:0]   out_d [16];

  logic [7:0]   inBytes [16];
  logic [1:0]   col, row;
  logic [7:0]   mixByte;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmulConst(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Row r is row 0 rotated right by r, so M[r][j] = ROW0[(j - r) mod 4].
  function automatic logic [3:0] coef(input logic [1:0] m);
    case (m)
      2'd0:    return ROW0[27:24];
      2'd1:    return ROW0[19:16];
      2'd2:    return ROW0[11:8];
      default: return ROW0[3:0];
    endcase
  endfunction

  genvar g;
  for (g = 0; g < 16; g++) begin : g_pack
    assign inBytes[g]                  = in_q[8*(15-g) +: 8];
    assign out_state[8*(15-g) +: 8]    = out_q[g];
  end

  assign col = idx_q[3:2];
  assign row = idx_q[1:0];

  // One output byte per cycle: XOR-sum over the four bytes of column col.
  always_comb begin
    mixByte = 8'h00;
    for (int j = 0; j < 4; j++) begin
      mixByte = mixByte ^ gmulConst(inBytes[{col, 2'(j)}], coef(2'(j) - row));
    end
  end

  // The index saturates at 15 and is cleared only on accept or reset.
  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    idx_d   = idx_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in_state;
          idx_d   = 4'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        out_d[idx_q] = mixByte;
        if (idx_q == 4'd15) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      idx_q   <= '0;
      for (int b = 0; b < 16; b++) begin
        out_q[b] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      idx_q   <= idx_d;
      for (int b = 0; b < 16; b++) begin
        out_q[b] <= out_d[b];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);

endmodule

// File: tb/tb_mix_columns_iter.sv
// -----------------------------------------------------------------------------
// tb_mix_columns_iter
//   Directed bench for mix_columns_iter. Instance 0 is forward MixColumns,
//   instance 1 is InvMixColumns; both share clock and reset. Expected results
//   are queued when a state is accepted and compared when out_valid appears.
// -----------------------------------------------------------------------------
module tb_mix_columns_iter;

  localparam logic [127:0] VEC_A   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] RES_A   = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] VEC_B   = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] RES_B   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  logic         clk;
  logic         rst;
  logic [127:0] inState  [2];
  logic         inValid  [2];
  logic         inReady  [2];
  logic [127:0] outState [2];
  logic         outValid [2];
  logic         outReady [2];
  logic         busy     [2];

  logic [127:0] expQ [$];
  int           compared;
  int           mismatched;

  mix_columns_iter #(.INVERSE(1'b0)) dutFwd (
    .clk       (clk),
    .rst       (rst),
    .in_state  (inState[0]),
    .in_valid  (inValid[0]),
    .in_ready  (inReady[0]),
    .out_state (outState[0]),
    .out_valid (outValid[0]),
    .out_ready (outReady[0]),
    .busy      (busy[0])
  );

  mix_columns_iter #(.INVERSE(1'b1)) dutInv (
    .clk       (clk),
    .rst       (rst),
    .in_state  (inState[1]),
    .in_valid  (inValid[1]),
    .in_ready  (inReady[1]),
    .out_state (outState[1]),
    .out_valid (outValid[1]),
    .out_ready (outReady[1]),
    .busy      (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial GF(2^8) multiply used only by the reference model.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mixModel(input logic [127:0] s, input bit inv);
    logic [7:0]   row0 [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inv) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gm(row0[(j - rr + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        end
        r[127 - 8*(4*c + rr) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Accepts one vector on unit u, waits for out_valid within a bounded
  // budget, checks latency and the popped scoreboard entry. When noisy,
  // in_valid is toggled with junk data while the unit is computing.
  task automatic applyStimulus(input int u, input logic [127:0] vec,
                               input logic [127:0] expected, input bit noisy,
                               input string tag);
    int           n;
    logic [127:0] exp;
    expQ.push_back(expected);
    inState[u] = vec;
    inValid[u] = 1'b1;
    tick();
    inValid[u] = 1'b0;
    checkOutput({tag, " busy after accept"}, 128'(busy[u]), 128'd1);
    n = 1;
    while (!outValid[u] && n < 40) begin
      if (noisy) begin
        inValid[u] = n[0];
        inState[u] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      n++;
    end
    inValid[u] = 1'b0;
    checkOutput({tag, " latency"}, 128'(n), 128'd17);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 128'hx;
    checkOutput({tag, " result"}, outState[u], exp);
  endtask

  initial begin
    logic [127:0] held;
    logic [127:0] nextVec;
    int           accepts;
    int           lastAcc;
    bit           acc;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    for (int u = 0; u < 2; u++) begin
      inState[u]  = '0;
      inValid[u]  = 1'b0;
      outReady[u] = 1'b1;
    end
    #1 rst = 1'b1;
    tick();
    tick();

    checkOutput("reset out_state", outState[0], 128'd0);
    checkOutput("reset out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("reset busy",      128'(busy[0]), 128'd0);
    checkOutput("reset in_ready",  128'(inReady[0]), 128'd1);
    rst = 1'b0;
    tick();

    $display("[TB] forward vector A");
    applyStimulus(0, VEC_A, RES_A, 1'b0, "fwdA");
    tick();
    checkOutput("fwdA out_valid one cycle", 128'(outValid[0]), 128'd0);
    checkOutput("fwdA in_ready back",       128'(inReady[0]), 128'd1);
    checkOutput("fwdA out_state retained",  outState[0], RES_A);

    $display("[TB] forward vector B with in_valid noise during CALC");
    applyStimulus(0, VEC_B, RES_B, 1'b1, "fwdB");
    tick();
    checkOutput("fwdB back to idle", 128'(inReady[0]), 128'd1);

    $display("[TB] inverse vector");
    applyStimulus(1, RES_A, VEC_A, 1'b0, "invA");
    tick();
    checkOutput("invA back to idle", 128'(inReady[1]), 128'd1);

    $display("[TB] backpressure");
    outReady[0] = 1'b0;
    applyStimulus(0, VEC_A, RES_A, 1'b0, "bp");
    held = RES_A;
    for (int i = 0; i < 10; i++) begin
      inValid[0] = i[0];
      inState[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      checkOutput("bp out_valid held", 128'(outValid[0]), 128'd1);
      checkOutput("bp out_state held", outState[0], held);
      checkOutput("bp in_ready low",   128'(inReady[0]), 128'd0);
    end
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    tick();
    checkOutput("bp released in_ready",  128'(inReady[0]), 128'd1);
    checkOutput("bp released out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("bp released busy",      128'(busy[0]), 128'd0);
    checkOutput("bp out_state retained", outState[0], held);

    $display("[TB] reset in the middle of CALC");
    inState[0] = VEC_B;
    inValid[0] = 1'b1;
    tick();
    inValid[0] = 1'b0;
    repeat (7) tick();
    checkOutput("abort still busy", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort out_state", outState[0], 128'd0);
    checkOutput("abort out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("abort busy",      128'(busy[0]), 128'd0);
    checkOutput("abort in_ready",  128'(inReady[0]), 128'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(0, VEC_A, RES_A, 1'b0, "postReset");
    tick();

    $display("[TB] back-to-back accepts");
    accepts    = 0;
    lastAcc    = -1;
    inState[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    inValid[0] = 1'b1;
    for (int cyc = 0; cyc < 120 && (accepts < 4 || expQ.size() > 0); cyc++) begin
      if (accepts == 4) inValid[0] = 1'b0;
      acc = inReady[0] && inValid[0];
      if (acc) expQ.push_back(mixModel(inState[0], 1'b0));
      tick();
      if (acc) begin
        if (lastAcc >= 0) checkOutput("b2b spacing", 128'(cyc - lastAcc), 128'd18);
        lastAcc = cyc;
        accepts++;
        nextVec    = {$urandom(), $urandom(), $urandom(), $urandom()};
        inState[0] = nextVec;
      end
      if (outValid[0]) begin
        if (expQ.size() > 0) begin
          checkOutput("b2b result", outState[0], expQ.pop_front());
        end else begin
          checkOutput("b2b unexpected out_valid", 128'(outValid[0]), 128'd0);
        end
      end
    end
    inValid[0] = 1'b0;
    checkOutput("b2b accepts",  128'(accepts), 128'd4);
    checkOutput("b2b drained",  128'(expQ.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 Parameter INVERSE, default 0, meaning: 0 selects forward MixColumns (row 0 constants 02 03 01 01); 1 selects InvMixColumns (row 0 constants 0e 0b 0d 09).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_state  input  128  AES state after ShiftRows; byte 0 = bits [127:120]; column c = bytes 4c..4c+3; byte 4c+r is row r.
REQ-005 in_valid  input  1  in_state is valid this cycle.
REQ-006 in_ready  output  1  block can accept a new state.
REQ-007 out_state  output  128  mixed state, same byte ordering as in_state.
REQ-008 out_valid  output  1  out_state is valid.
REQ-009 out_ready  input  1  consumer accepts out_state.
REQ-010 busy  output  1  high in CALC state.

Function
REQ-011 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in CALC.
REQ-013 IDLE: on in_valid=1 at a clock edge, in_state SHALL be latched into an internal 128-bit register, byte index cleared to 0, state -> CALC.
REQ-014 CALC: one output byte per cycle, index k = 0..15, r = k mod 4, c = k div 4.
REQ-015 Output byte (r,c) SHALL be the GF(2^8) XOR-sum over j=0..3 of M[r][j]*s[j][c], with M row r being row 0 constants rotated right by r, and reduction polynomial 0x11b.
REQ-016 GF multiply by constants SHALL be built from xtime (shift left, XOR 0x1b on carry-out); combinational per cycle, no multi-cycle multiply.
REQ-017 Each computed byte SHALL be written into byte k of the out_state register at the edge ending its cycle; unwritten bytes hold previous values.
REQ-018 When k=15 is written, state SHALL go to DONE on the same edge; accept-to-out_valid latency is exactly 17 edges (1 accept + 16 compute).
REQ-019 The latched input register SHALL not change during CALC or DONE; in_valid is ignored outside IDLE.
REQ-020 DONE: out_state and out_valid SHALL hold stable until out_ready=1 at a clock edge, then state -> IDLE; out_state retains its value in IDLE.
REQ-021 A new state SHALL not be accepted on the same edge as DONE->IDLE (in_ready is 0 in DONE); minimum spacing between accepts is 18 cycles.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Byte index counter is 4 bits and SHALL not wrap; it is only cleared on accept or reset.

Reset
REQ-024 On rst=1, asynchronously: state IDLE, input register 0, out_state 0, index 0, out_valid 0, busy 0; in_ready 1 once in IDLE.
REQ-025 Reset asserted mid-CALC or in DONE SHALL abort the operation; no partial result is ever presented with out_valid=1.
REQ-026 After rst deasserts, the first in_valid at a clock edge SHALL be accepted normally.

Verification
REQ-027 INVERSE=0, in_state=d4bf5d30e0b452aeb84111f11e2798e5, out_ready=1 -> out_state=046681e5e0cb199a48f8d37a2806264c, out_valid rises exactly 17 edges after accept, lasts 1 cycle.
REQ-028 INVERSE=0, columns db135345 f20a225c 01010101 c6c6c6c6 -> out_state=8e4da1bc9fdc589d01010101c6c6c6c6.
REQ-029 INVERSE=1, in_state=046681e5e0cb199a48f8d37a2806264c -> out_state=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-030 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_state/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-031 rst pulsed at CALC index 7 -> all outputs 0, in_ready=1; next vector (REQ-027) completes correctly with 17-edge latency.
REQ-032 Back-to-back: in_valid held high continuously with out_ready=1 -> accepts spaced exactly 18 cycles, each result correct.
